fetch_pc_gen: RTL and testbench
===============================

# fetch_pc_gen

Instruction-fetch front end: owns the fetch PC register, queries the branch target buffer each cycle, issues one-outstanding-request fetches to instruction memory, and hands fetched instructions plus their prediction to ID through a one-entry output slot. It sits directly upstream of the BTB lookup and consumes its hit/target. EX mispredict redirects enter here. Resolved-branch updates go from EX straight to the BTB and do not pass through this block.

## Interface
- RESET_PC, 32'h0000_0000, fetch address after reset
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- btb_pc  out  32  query PC to BTB, always equals pc_q
- btb_hit  in  1  BTB hit for btb_pc
- btb_target  in  32  BTB predicted target
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch address
- imem_gnt  in  1  request accepted this cycle when imem_req=1
- imem_rvalid  in  1  read data valid, earliest one cycle after gnt
- imem_rdata  in  32  instruction word
- redirect_en  in  1  EX mispredict/redirect, one-cycle pulse
- redirect_pc  in  32  correct fetch address
- id_ready  in  1  ID accepts if_* this cycle
- if_valid  out  1  output slot holds an instruction
- if_pc  out  32  its PC
- if_inst  out  32  its instruction word
- if_pred_taken  out  1  fetch predicted taken
- if_pred_target  out  32  predicted next PC, pc+4 when not taken

## Operation
- Registers: pc_q, state {FS_REQ, FS_WAIT}, kill, pend_pc/pend_taken/pend_target, output slot.
- slot_free = !if_valid || id_ready. The slot clears when id_ready=1 and no new load occurs.
- FS_REQ: imem_req = slot_free. imem_addr = pc_q. On gnt: latch pend_* (taken=btb_hit, target=btb_hit?btb_target:pc_q+4), pc_q <= predicted next PC, go FS_WAIT.
- FS_WAIT, rvalid, kill=0: load slot from pend_* and imem_rdata, if_valid <= 1. Same cycle, imem_req = slot_free with imem_addr = pc_q. On gnt, re-latch pend_* and stay in FS_WAIT; otherwise go to FS_REQ.
- FS_WAIT, rvalid, kill=1: drop the data, clear kill, go to FS_REQ, imem_req=0 this cycle.
- imem_rvalid in FS_REQ is ignored.
- Redirect takes highest priority:
  - pc_q <= {redirect_pc[31:2],2'b00}.
  - if_valid <= 0, and the slot is not loaded.
  - imem_req forced 0 that cycle, so no gnt is possible.
  - In FS_WAIT without rvalid: kill <= 1.
  - In FS_WAIT with rvalid: drop the data, go to FS_REQ, kill <= 0.
- pc_q+4 wraps modulo 2^32. pc_q[1:0] is always 0.
- Reset outputs: if_valid 0, if_pc 0, if_inst 0, if_pred_taken 0, if_pred_target 0, imem_req 0, btb_pc = RESET_PC. Also state FS_REQ, kill 0.
- Reset mid-fetch abandons the outstanding request. Imem is reset by the same rst.

## Timing
- imem_req and imem_addr are combinational from registers, rvalid, id_ready and redirect_en.
- The BTB lookup is same-cycle combinational on btb_pc.
- gnt in cycle N, rvalid in N+1 gives if_valid in N+2.
- With a zero-wait memory and id_ready held high, throughput is one instruction per cycle.
- The slot holds its value while if_valid=1 and id_ready=0.
- The first request is issued in the cycle after rst deasserts.

## Configuration
- FETCH_BTB_PRED_EN defined: prediction from btb_hit/btb_target as above.
- FETCH_BTB_PRED_EN undefined:
  - Next PC is always pc_q+4. btb_hit/btb_target are ignored.
  - if_pred_taken = 0 and if_pred_target = pc+4.
  - btb_pc is still driven.

## Structure
- The shared package fetch_pkg holds fetch_state_e (FS_REQ, FS_WAIT), the RESET_PC default constant, and a packed struct fetch_pkt_t {pc, inst, pred_taken, pred_target}.
- No sub-module. The output slot and FSM are small enough to keep inline.

## Test plan
- Reset release, zero-wait memory, id_ready=1, no BTB hits -> if_pc = 0, 4, 8, 12 on consecutive cycles from the second cycle after gnt; if_pred_target = pc+4.
- btb_hit=1, btb_target=0x100 at pc 0x8 -> next imem_addr 0x100; packet for 0x8 has pred_taken=1, pred_target=0x100. With FETCH_BTB_PRED_EN undefined -> next addr 0xC, pred_taken=0.
- id_ready=0 for 3 cycles with if_valid=1 -> if_* stable; imem_req=0 once a second response is captured; fetching resumes after id_ready=1 with no loss or duplication.
- redirect_en with redirect_pc=0x200 while in FS_WAIT -> the next rvalid is dropped (if_valid stays 0), then a fetch of 0x200 follows. Also cover redirect together with rvalid in the same cycle.
- pc 0xFFFF_FFFC with no hit -> next fetch at 0x0000_0000.
- Assert rst for one cycle while in FS_WAIT -> outputs return to reset values; the next request is for RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared fetch-stage types and the reset fetch address.
package fetch_pkg;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    typedef enum logic {FS_REQ, FS_WAIT} fetch_state_e;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        pred_taken;
        logic [31:0] pred_target;
    } fetch_pkt_t;
endpackage

// File: rtl/fetch_pc_gen_if.sv
// fetch_pc_gen_if: BTB query, imem request/response, EX redirect and ID output slot signals.
interface fetch_pc_gen_if;
    logic [31:0] btb_pc;
    logic        btb_hit;
    logic [31:0] btb_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_pred_taken;
    logic [31:0] if_pred_target;
    modport master (
        output btb_pc, imem_req, imem_addr, if_valid, if_pc, if_inst, if_pred_taken, if_pred_target,
        input  btb_hit, btb_target, imem_gnt, imem_rvalid, imem_rdata, redirect_en, redirect_pc, id_ready
    );
    modport slave (
        input  btb_pc, imem_req, imem_addr, if_valid, if_pc, if_inst, if_pred_taken, if_pred_target,
        output btb_hit, btb_target, imem_gnt, imem_rvalid, imem_rdata, redirect_en, redirect_pc, id_ready
    );
endinterface

// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: fetch PC owner issuing one-outstanding imem fetches into a one-entry ID slot.
// Define FETCH_BTB_PRED_EN to steer the next PC from the BTB; otherwise fetch is always sequential.
module fetch_pc_gen
    import fetch_pkg::*;
(
    input logic            clk,
    input logic            rst,
    fetch_pc_gen_if.master f
);
    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d, pc_inc, pred_target;
    logic         kill_q, kill_d, valid_q, valid_d;
    fetch_pkt_t   pend_q, pend_d, slot_q, slot_d;
    logic         slot_free, rsp, fire, load, pred_taken, unused_bits;

    assign pc_inc = pc_q + 32'd4;
`ifdef FETCH_BTB_PRED_EN
    assign pred_taken  = f.btb_hit;
    assign pred_target = f.btb_hit ? {f.btb_target[31:2], 2'b00} : pc_inc;
    assign unused_bits = ^{f.btb_target[1:0], f.redirect_pc[1:0]};
`else
    assign pred_taken  = 1'b0;
    assign pred_target = pc_inc;
    assign unused_bits = ^{f.btb_hit, f.btb_target, f.redirect_pc[1:0]};
`endif

    always_comb begin
        rsp        = state_q == FS_WAIT && f.imem_rvalid;
        slot_free  = !valid_q || f.id_ready;
        // a killed response never chains a new request; reset also holds the request low
        f.imem_req = !rst && !f.redirect_en && slot_free && (state_q == FS_REQ || (rsp && !kill_q));
        f.imem_addr = pc_q;
        f.btb_pc    = pc_q;
        fire    = f.imem_req && f.imem_gnt;
        load    = rsp && !kill_q && !f.redirect_en;
        state_d = fire ? FS_WAIT : (rsp ? FS_REQ : state_q);
        kill_d  = f.redirect_en ? (state_q == FS_WAIT && !f.imem_rvalid) : (rsp ? 1'b0 : kill_q);
        pc_d    = f.redirect_en ? {f.redirect_pc[31:2], 2'b00} : (fire ? pred_target : pc_q);
        pend_d  = fire ? {pc_q, 32'd0, pred_taken, pred_target} : pend_q;
        slot_d  = slot_q;
        if (load) begin
            slot_d      = pend_q;
            slot_d.inst = f.imem_rdata;
        end
        valid_d = !f.redirect_en && (load || (valid_q && !f.id_ready));
        f.if_valid       = valid_q;
        f.if_pc          = slot_q.pc;
        f.if_inst        = slot_q.inst;
        f.if_pred_taken  = slot_q.pred_taken;
        f.if_pred_target = slot_q.pred_target;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FS_REQ;
            pc_q    <= RESET_PC;
            kill_q  <= 1'b0;
            pend_q  <= '0;
            slot_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            kill_q  <= kill_d;
            pend_q  <= pend_d;
            slot_q  <= slot_d;
            valid_q <= valid_d;
        end
    end
endmodule

// File: tb/tb_fetch_pc_gen.sv
// tb_fetch_pc_gen: directed bench with a fetch-order scoreboard plus hand-computed checkpoints.
module tb_fetch_pc_gen;
    import fetch_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_pc_gen_if f();
    fetch_pc_gen dut (.clk(clk), .rst(rst), .f(f));

    int total = 0;
    int bad = 0;

    logic        gnt_en = 1'b1;
    int          lat = 1;
    logic        hit_en = 1'b0;
    logic [31:0] hit_pc = 32'd0;
    logic [31:0] hit_tgt = 32'd0;
    logic        mem_pend = 1'b0;
    logic [31:0] mem_addr = 32'd0;
    int          mem_cnt = 0;

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    assign f.btb_hit     = hit_en && f.btb_pc == hit_pc;
    assign f.btb_target  = hit_tgt;
    assign f.imem_gnt    = f.imem_req && gnt_en;
    assign f.imem_rvalid = mem_pend && mem_cnt == 1;
    assign f.imem_rdata  = word(mem_addr);

    // memory answers each granted request after lat cycles
    always @(posedge clk) begin
        if (rst) mem_pend <= 1'b0;
        else if (f.imem_gnt) begin
            mem_pend <= 1'b1;
            mem_addr <= f.imem_addr;
            mem_cnt  <= lat;
        end else if (f.imem_rvalid) mem_pend <= 1'b0;
        else if (mem_pend) mem_cnt <= mem_cnt - 1;
    end

    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] tgt;
    } exp_t;
    exp_t        q[$];
    exp_t        e;
    logic [31:0] mpc = RESET_PC;
    logic        held = 1'b0;
    logic [31:0] h_pc, h_inst, h_tgt;
    logic        h_tk;

    // scoreboard: every granted, non-flushed fetch must reach ID once, in order
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            mpc = RESET_PC;
            held = 1'b0;
        end else begin
            chk("btb_pc", f.btb_pc, mpc);
            if (held) begin
                chk("hold_valid", {31'd0, f.if_valid}, 32'd1);
                chk("hold_pc", f.if_pc, h_pc);
                chk("hold_inst", f.if_inst, h_inst);
                chk("hold_taken", {31'd0, f.if_pred_taken}, {31'd0, h_tk});
                chk("hold_tgt", f.if_pred_target, h_tgt);
            end
            if (f.if_valid && f.id_ready) begin
                if (q.size() == 0) chk("spurious_pkt", {31'd0, f.if_valid}, 32'd0);
                else begin
                    e = q.pop_front();
                    chk("pkt_pc", f.if_pc, e.pc);
                    chk("pkt_inst", f.if_inst, word(e.pc));
                    chk("pkt_taken", {31'd0, f.if_pred_taken}, {31'd0, e.taken});
                    chk("pkt_tgt", f.if_pred_target, e.tgt);
                end
            end
            held = f.if_valid && !f.id_ready && !f.redirect_en;
            h_pc = f.if_pc;
            h_inst = f.if_inst;
            h_tk = f.if_pred_taken;
            h_tgt = f.if_pred_target;
            if (f.redirect_en) begin
                chk("redir_req", {31'd0, f.imem_req}, 32'd0);
                q.delete();
                mpc = {f.redirect_pc[31:2], 2'b00};
            end else if (f.imem_gnt) begin
                chk("req_addr", f.imem_addr, mpc);
`ifdef FETCH_BTB_PRED_EN
                e.taken = hit_en && mpc == hit_pc;
`else
                e.taken = 1'b0;
`endif
                e.pc = mpc;
                e.tgt = e.taken ? hit_tgt : mpc + 32'd4;
                q.push_back(e);
                mpc = e.tgt;
            end
        end
    end

    logic [31:0] exp_next;
    logic        exp_tk;

    initial begin
        f.id_ready = 1'b1;
        f.redirect_en = 1'b0;
        f.redirect_pc = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", {31'd0, f.if_valid}, 32'd0);
        chk("rst_pc", f.if_pc, 32'd0);
        chk("rst_inst", f.if_inst, 32'd0);
        chk("rst_taken", {31'd0, f.if_pred_taken}, 32'd0);
        chk("rst_tgt", f.if_pred_target, 32'd0);
        chk("rst_req", {31'd0, f.imem_req}, 32'd0);
        chk("rst_btb_pc", f.btb_pc, 32'd0);
        // sequential stream, zero-wait memory
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("first_req", {31'd0, f.imem_req}, 32'd1);
        chk("first_addr", f.imem_addr, 32'd0);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("seq_valid", {31'd0, f.if_valid}, 32'd1);
            chk("seq_pc", f.if_pc, 32'(i * 4));
            chk("seq_tgt", f.if_pred_target, 32'(i * 4 + 4));
        end
        // ID stall with nothing in flight
        @(posedge clk); #1; gnt_en = 1'b0;
        @(negedge clk);
        chk("blk_pc", f.if_pc, 32'd16);
        @(posedge clk); #1; gnt_en = 1'b1; f.id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_req", {31'd0, f.imem_req}, 32'd0);
            chk("stall_pc", f.if_pc, 32'd20);
        end
        @(posedge clk); #1; f.id_ready = 1'b1;
        @(negedge clk);
        chk("resume_req", {31'd0, f.imem_req}, 32'd1);
        chk("resume_addr", f.imem_addr, 32'd24);
        repeat (2) @(negedge clk);
        chk("resume_pc", f.if_pc, 32'd24);
        // redirect while waiting: the late response is killed
        @(posedge clk); #1; lat = 2;
        @(negedge clk);
        @(posedge clk); #1; f.redirect_en = 1'b1; f.redirect_pc = 32'h203;
        @(negedge clk);
        @(posedge clk); #1; f.redirect_en = 1'b0;
        @(negedge clk);
        chk("kill_rvalid", {31'd0, f.imem_rvalid}, 32'd1);
        chk("kill_valid", {31'd0, f.if_valid}, 32'd0);
        chk("kill_req", {31'd0, f.imem_req}, 32'd0);
        @(negedge clk);
        chk("kill_next_req", {31'd0, f.imem_req}, 32'd1);
        chk("kill_next_addr", f.imem_addr, 32'h200);
        repeat (3) @(negedge clk);
        chk("kill_pkt_valid", {31'd0, f.if_valid}, 32'd1);
        chk("kill_pkt_pc", f.if_pc, 32'h200);
        // redirect coinciding with rvalid, then wrap at the top of memory
        @(posedge clk); #1; lat = 1;
        @(negedge clk);
        @(posedge clk); #1; f.redirect_en = 1'b1; f.redirect_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        chk("rvred_rvalid", {31'd0, f.imem_rvalid}, 32'd1);
        @(posedge clk); #1; f.redirect_en = 1'b0;
        @(negedge clk);
        chk("rvred_valid", {31'd0, f.if_valid}, 32'd0);
        chk("wrap_addr0", f.imem_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        chk("wrap_req", {31'd0, f.imem_req}, 32'd1);
        chk("wrap_addr1", f.imem_addr, 32'd0);
        @(negedge clk);
        chk("wrap_pkt_pc", f.if_pc, 32'hFFFF_FFFC);
        chk("wrap_pkt_tgt", f.if_pred_target, 32'd0);
        @(negedge clk);
        chk("wrap_pkt2_pc", f.if_pc, 32'd0);
        // reset while a fetch is outstanding
        @(posedge clk); #1; lat = 2;
        @(negedge clk);
        @(posedge clk); #1; rst = 1'b1;
        @(negedge clk);
        chk("mrst_req", {31'd0, f.imem_req}, 32'd0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("mrst_valid", {31'd0, f.if_valid}, 32'd0);
        chk("mrst_pc", f.if_pc, 32'd0);
        chk("mrst_tgt", f.if_pred_target, 32'd0);
        chk("mrst_req2", {31'd0, f.imem_req}, 32'd1);
        chk("mrst_addr", f.imem_addr, RESET_PC);
        repeat (3) @(negedge clk);
        chk("mrst_pkt_pc", f.if_pc, 32'd0);
        // BTB hit at pc 8
`ifdef FETCH_BTB_PRED_EN
        exp_tk = 1'b1;
        exp_next = 32'h100;
`else
        exp_tk = 1'b0;
        exp_next = 32'hC;
`endif
        @(posedge clk); #1; rst = 1'b1; lat = 1; hit_en = 1'b1; hit_pc = 32'd8; hit_tgt = 32'h100;
        @(negedge clk);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        repeat (3) @(negedge clk);
        chk("btb_next_addr", f.imem_addr, exp_next);
        @(negedge clk);
        chk("btb_pkt_pc", f.if_pc, 32'd8);
        chk("btb_pkt_taken", {31'd0, f.if_pred_taken}, {31'd0, exp_tk});
        chk("btb_pkt_tgt", f.if_pred_target, exp_next);
        @(negedge clk);
        chk("btb_after_pc", f.if_pc, exp_next);
        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
